fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the decode-stage control unit.
// Opcode constants live here so fetch and decode agree on what HLT looks like.
package fetch_stage_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0]         OPC_HLT   = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return opcode == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
// slave is the fetch stage's view; master is the surrounding pipeline/memory.
interface fetch_stage_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [PC_WIDTH-1:0]    if_id_pc_plus2;
    logic                   if_id_valid;
    logic                   halted;

    modport slave (
        input  stall, redirect, redirect_pc, imem_data, imem_ready,
        output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
    );

    modport master (
        output stall, redirect, redirect_pc, imem_data, imem_ready,
        input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// Priority: reset, flush (bubble), hold, load; with no control asserted it keeps its value.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   hold,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] d_instr,
    input  logic [PC_WIDTH-1:0]    d_pc_plus2,
    output logic [INSTR_WIDTH-1:0] q_instr,
    output logic [PC_WIDTH-1:0]    q_pc_plus2,
    output logic                   q_valid
);

    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [PC_WIDTH-1:0]    pc_plus2_reg;
    logic                   valid_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_reg    <= INSTR_WIDTH'(NOP_INSTR);
            pc_plus2_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (!hold && load) begin
            instr_reg    <= d_instr;
            pc_plus2_reg <= d_pc_plus2;
            valid_reg    <= 1'b1;
        end
    end

    assign q_instr    = instr_reg;
    assign q_pc_plus2 = pc_plus2_reg;
    assign q_valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_addr and loads IF/ID.
// Handles stalls, ID branch redirects, memory wait states and a sticky halt on HLT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_stage_if.slave bus
);

    fetch_state_t        state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [PC_WIDTH-1:0] pc_plus2;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                ifid_load, ifid_hold, ifid_flush;

    assign pc_plus2        = pc_reg + PC_WIDTH'(2);
    assign redirect_target = {bus.redirect_pc[PC_WIDTH-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            state_reg <= RUN;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

    // A redirect outranks everything in RUN, so an HLT on the wrong path never halts.
    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        ifid_load  = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (bus.redirect) begin
                    pc_next    = redirect_target;
                    ifid_flush = 1'b1;
                end else if (bus.stall) begin
                    ifid_hold = 1'b1;
                end else if (!bus.imem_ready) begin
                    ifid_flush = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    if (is_hlt(bus.imem_data[INSTR_WIDTH-1 -: 4])) begin
                        state_next = HALTED;
                    end else begin
                        pc_next = pc_plus2;
                    end
                end
            end
            HALTED: begin
                if (bus.stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .hold      (ifid_hold),
        .flush     (ifid_flush),
        .d_instr   (bus.imem_data),
        .d_pc_plus2(pc_plus2),
        .q_instr   (bus.if_id_instr),
        .q_pc_plus2(bus.if_id_pc_plus2),
        .q_valid   (bus.if_id_valid)
    );

    assign bus.imem_addr = pc_reg;
    assign bus.halted    = (state_reg == HALTED);

endmodule
